// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor computing D = A - B - Bin (mod 2^WIDTH) and the final
// borrow-out Bout, one bit per clock, LSB first.
//
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the registered
// signed-overflow flag V (borrow into the MSB XOR final borrow-out).
//
// Handshake: start is sampled only while idle (busy=0, done=0); the operands
// are captured on the accepting edge. busy is high for the WIDTH cycles of
// the serial pass, and done pulses for exactly one cycle once D/Bout hold the
// new result. start is ignored at all other times. There is no back-pressure.
//
// state_dbg exposes the FSM state for observation (0=IDLE, 1=SHIFT, 2=DONE).

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             V,
`endif
    output logic [1:0]       state_dbg
);

    // Counter must hold WIDTH-1 without wrapping; one extra bit of headroom.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Partial result: holds the bits already produced. The bit being produced
    // this cycle completes the word, so WIDTH-1 stored bits are sufficient.
    logic [WIDTH-2:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_full;

    // Full-subtractor cell on the current LSBs plus the running borrow.
    always_comb begin
        d_bit    = a_sr[0] ^ b_sr[0] ^ br;
        br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_full = {d_bit, res};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, serial shift and bit counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sr <= A;
            b_sr <= B;
            res  <= '0;
            br   <= Bin;
            cnt  <= '0;
        end else if (busy) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            res  <= res_full[WIDTH-1:1];
            br   <= br_next;
            if (!last_bit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Visible result registers: updated only on the final serial edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D    <= '0;
            Bout <= 1'b0;
        end else if (last_bit) begin
            D    <= res_full;
            Bout <= br_next;
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Signed overflow: borrow into the MSB differs from the borrow out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            V <= 1'b0;
        end else if (last_bit) begin
            V <= br ^ br_next;
        end
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed plus randomized checks of serial_subtractor at WIDTH=8 against an
// arithmetic reference model. Honours SERIAL_SUBTRACTOR_OVF_EN for V.

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d_out;
    logic         bout;
    logic [1:0]   state_dbg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         v_out;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {V, Bout, D}
    logic [W+1:0] exp_q[$];
    logic [W-1:0] last_d;
    logic         last_bout;
    logic         last_v;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (a_in),
        .B         (b_in),
        .Bin       (bin_in),
        .busy      (busy),
        .done      (done),
        .D         (d_out),
        .Bout      (bout),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .V         (v_out),
`endif
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        int diff;
        int sdiff;
        logic [W-1:0] d;
        logic bo;
        logic v;
        diff  = int'(a) - int'(b) - int'(bin);
        sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d     = W'(diff);
        bo    = (int'(a) < int'(b) + int'(bin));
        v     = (sdiff < -(2 ** (W - 1))) || (sdiff > (2 ** (W - 1)) - 1);
        return {v, bo, d};
    endfunction

    task automatic check_hold(input string tag);
        chk({tag, "_d_hold"}, 32'(d_out), 32'(last_d));
        chk({tag, "_bout_hold"}, 32'(bout), 32'(last_bout));
    endtask

    // Driver: run one full operation from IDLE (called #1 after a posedge or
    // any time before the accepting edge). glitch_edge>0 pulses start with
    // A=FF just before that SHIFT edge, which must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int glitch_edge, input string tag);
        logic [W+1:0] e;
        exp_q.push_back(model(a, b, bin));
        a_in   = a;
        b_in   = b;
        bin_in = bin;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        bin_in = 1'($urandom);
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        chk({tag, "_done_e0"}, 32'(done), 32'd0);
        for (int k = 1; k <= W; k++) begin
            if (k == glitch_edge) begin
                start = 1'b1;
                a_in  = 8'hFF;
            end
            @(posedge clk); #1;
            start  = 1'b0;
            a_in   = W'($urandom);
            b_in   = W'($urandom);
            bin_in = 1'($urandom);
            if (k < W) begin
                chk($sformatf("%s_busy_e%0d", tag, k), 32'(busy), 32'd1);
                chk($sformatf("%s_done_e%0d", tag, k), 32'(done), 32'd0);
                if (k == 4) check_hold(tag);
            end else begin
                chk({tag, "_busy_end"}, 32'(busy), 32'd0);
                chk({tag, "_done_end"}, 32'(done), 32'd1);
                if (exp_q.size() == 0) begin
                    chk({tag, "_q_empty"}, 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_D"}, 32'(d_out), 32'(e[W-1:0]));
                    chk({tag, "_Bout"}, 32'(bout), 32'(e[W]));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    chk({tag, "_V"}, 32'(v_out), 32'(e[W+1]));
`endif
                    last_d    = e[W-1:0];
                    last_bout = e[W];
                    last_v    = e[W+1];
                end
            end
        end
        @(posedge clk); #1;
        chk({tag, "_done_after"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_hold({tag, "_idle"});
    endtask

    // Directed sequence
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        bin_in    = 1'b0;
        last_d    = '0;
        last_bout = 1'b0;
        last_v    = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_D", 32'(d_out), 32'd0);
        chk("rst_Bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("rst_V", 32'(v_out), 32'd0);
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle with start low: nothing moves.
        for (int i = 0; i < 3; i++) begin
            a_in = W'($urandom);
            @(posedge clk); #1;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end

        run_op(8'h05, 8'h03, 1'b0, 0, "t05m03");
        run_op(8'h03, 8'h05, 1'b0, 0, "t03m05");
        run_op(8'h80, 8'h01, 1'b0, 0, "t80m01");
        run_op(8'h00, 8'h00, 1'b1, 0, "t00m00b");
        run_op(8'hFF, 8'hFF, 1'b1, 0, "tFFmFFb");
        run_op(8'h05, 8'h03, 1'b0, 3, "glitch");

        // Reset mid-SHIFT: outputs clear immediately, no done follows.
        a_in   = 8'h5A;
        b_in   = 8'h21;
        bin_in = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_D", 32'(d_out), 32'd0);
        chk("midrst_Bout", 32'(bout), 32'd0);
        exp_q.delete();
        last_d    = '0;
        last_bout = 1'b0;
        last_v    = 1'b0;
        #1;
        rst = 1'b0;
        // Accepted on the very first edge after reset release.
        run_op(8'h0A, 8'h04, 1'b0, 0, "postrst");

        // Randomized operands with back-to-back starts.
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0,
                   $sformatf("rnd%0d", i));
        end

        chk("q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
